// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - 8-bit LCD write driver: power-up init ROM, edge-triggered requests, 1-entry holding buffer
module lcd_bus_driver #(
  parameter int T_PWRUP = 300000,
  parameter int T_EXEC  = 800,
  parameter int T_CLR   = 32800,
  parameter int T_SU    = 2,
  parameter int T_EH    = 12,
  parameter int T_HD    = 2
) (
  input  logic       clk_20m,
  input  logic       rst,
  input  logic       wr,
  input  logic       dr,
  input  logic [7:0] dbi,
  input  logic [7:0] direc,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       ready,
  output logic       ovf
);
  localparam int T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    init_idx;
  logic          init_done;
  logic          wr_q, dr_q;
  logic          buf_full, buf_rs;
  logic [7:0]    buf_byte;
  logic          wr_edge, dr_edge, deq, last;
  logic [7:0]    rom_byte;
  logic [CW-1:0] exec_load;

  assign wr_edge = wr & ~wr_q;
  assign dr_edge = dr & ~dr_q;
  assign deq     = (state == IDLE) && buf_full;
  // Every timed state loads N and leaves when the count reaches 1, so it lasts exactly N clocks.
  assign last    = (cnt <= CW'(1));
  assign lcd_rw  = 1'b0;
  assign ready   = init_done & ~buf_full;

  // Clear-display and return-home need the long execution time.
  assign exec_load = (!lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02)) ? CW'(T_CLR) : CW'(T_EXEC);

  always_comb begin
    rom_byte = 8'h06;
    case (init_idx)
      3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
      3'd3:             rom_byte = 8'h0C;
      3'd4:             rom_byte = 8'h01;
      default:          rom_byte = 8'h06;
    endcase
  end

  always_ff @(posedge clk_20m or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      cnt       <= CW'(T_PWRUP);
      init_idx  <= 3'd0;
      init_done <= 1'b0;
      wr_q      <= 1'b0;
      dr_q      <= 1'b0;
      buf_full  <= 1'b0;
      buf_rs    <= 1'b0;
      buf_byte  <= 8'h00;
      ovf       <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
    end else begin
      wr_q <= wr;
      dr_q <= dr;

      // Instruction wins a tie; a dequeue in the same clock frees the slot for the new request.
      if (wr_edge && dr_edge) ovf <= 1'b1;
      if (wr_edge || dr_edge) begin
        if (!buf_full || deq) begin
          buf_full <= 1'b1;
          buf_rs   <= ~dr_edge;
          buf_byte <= dr_edge ? direc : dbi;
        end else begin
          ovf <= 1'b1;
        end
      end else if (deq) begin
        buf_full <= 1'b0;
      end

      case (state)
        PWR_WAIT: begin
          if (last) state <= INIT;
          else      cnt   <= cnt - CW'(1);
        end
        INIT: begin
          lcd_rs <= 1'b0;
          lcd_db <= rom_byte;
          cnt    <= CW'(T_SU);
          state  <= SETUP;
        end
        IDLE: begin
          if (buf_full) begin
            lcd_rs <= buf_rs;
            lcd_db <= buf_byte;
            cnt    <= CW'(T_SU);
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (last) begin
            lcd_e <= 1'b1;
            cnt   <= CW'(T_EH);
            state <= E_HIGH;
          end else cnt <= cnt - CW'(1);
        end
        E_HIGH: begin
          if (last) begin
            lcd_e <= 1'b0;
            cnt   <= CW'(T_HD);
            state <= HOLD;
          end else cnt <= cnt - CW'(1);
        end
        HOLD: begin
          if (last) begin
            cnt   <= exec_load;
            state <= EXEC_WAIT;
          end else cnt <= cnt - CW'(1);
        end
        EXEC_WAIT: begin
          if (last) begin
            if (init_done) begin
              state <= IDLE;
            end else if (init_idx == 3'd5) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              init_idx <= init_idx + 3'd1;
              state    <= INIT;
            end
          end else cnt <= cnt - CW'(1);
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb/tb_lcd_bus_driver.sv - self-checking bench: timeline model of LCD transfers plus directed and random stimulus
module tb_lcd_bus_driver;
  localparam int T_PWRUP = 20;
  localparam int T_EXEC  = 8;
  localparam int T_CLR   = 30;
  localparam int T_SU    = 2;
  localparam int T_EH    = 3;
  localparam int T_HD    = 2;

  logic       clk_20m = 1'b0;
  logic       rst     = 1'b0;
  logic       wr      = 1'b0;
  logic       dr      = 1'b0;
  logic [7:0] dbi     = 8'h00;
  logic [7:0] direc   = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e, ready, ovf;
  logic [7:0] lcd_db;

  int errors = 0;
  int checks = 0;

  logic [7:0] init_exp [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_bus_driver #(
    .T_PWRUP(T_PWRUP), .T_EXEC(T_EXEC), .T_CLR(T_CLR),
    .T_SU(T_SU), .T_EH(T_EH), .T_HD(T_HD)
  ) dut (
    .clk_20m(clk_20m), .rst(rst), .wr(wr), .dr(dr), .dbi(dbi), .direc(direc),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .ready(ready), .ovf(ovf)
  );

  always #5 clk_20m = ~clk_20m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each transfer is a time window starting at its issue clock n0;
  // E is high for clocks [n0+T_SU, n0+T_SU+T_EH) and the next issue may happen at n0+period.
  int         n, free_at, t_issue, init_idx, init_end;
  logic       issued, cur_rs, m_wrq, m_drq, m_full, m_rs, m_ovf;
  logic [7:0] cur_db, m_byte;

  function automatic int period(input logic rs, input logic [7:0] b);
    int w;
    w = (!rs && (b == 8'h01 || b == 8'h02)) ? T_CLR : T_EXEC;
    return T_SU + T_EH + T_HD + w + 1;
  endfunction

  task automatic model_issue(input logic rs, input logic [7:0] b);
    cur_rs  = rs;
    cur_db  = b;
    issued  = 1'b1;
    t_issue = n;
    free_at = n + period(rs, b);
  endtask

  task automatic model_step();
    logic deq, ew, ed;
    deq = 1'b0;
    ew = wr && !m_wrq;
    ed = dr && !m_drq;
    m_wrq = wr;
    m_drq = dr;
    if (n >= free_at) begin
      if (init_idx < 6) begin
        model_issue(1'b0, init_exp[init_idx]);
        init_idx++;
        if (init_idx == 6) init_end = free_at - 1;
      end else if (m_full) begin
        model_issue(m_rs, m_byte);
        deq = 1'b1;
      end
    end
    if (ew && ed) m_ovf = 1'b1;
    if (ew || ed) begin
      if (!m_full || deq) begin
        m_full = 1'b1;
        m_rs   = !ed;
        m_byte = ed ? direc : dbi;
      end else m_ovf = 1'b1;
    end else if (deq) m_full = 1'b0;
  endtask

  always @(posedge clk_20m or negedge rst) begin
    if (!rst) begin
      n = 0; free_at = T_PWRUP + 1; t_issue = 0; init_idx = 0; init_end = 0;
      issued = 1'b0; cur_rs = 1'b0; cur_db = 8'h00;
      m_wrq = 1'b0; m_drq = 1'b0; m_full = 1'b0; m_rs = 1'b0; m_byte = 8'h00; m_ovf = 1'b0;
    end else begin
      n++;
      model_step();
    end
  end

  always @(negedge clk_20m) begin
    check("lcd_e", lcd_e, issued && n >= t_issue + T_SU && n < t_issue + T_SU + T_EH);
    check("lcd_rs", lcd_rs, cur_rs);
    check("lcd_db", lcd_db, cur_db);
    check("lcd_rw", lcd_rw, 1'b0);
    check("ready", ready, init_idx == 6 && n >= init_end && !m_full);
    check("ovf", ovf, m_ovf);
  end

  // Pulse monitor for the hand-computed expectations.
  int         ecnt = 0;
  int         e_w = 0;
  logic       e_prev = 1'b0;
  logic [7:0] p_db [$];
  logic       p_rs [$];
  int         p_t [$];
  int         p_w [$];

  always @(posedge clk_20m or negedge rst) begin
    if (!rst) ecnt = 0;
    else      ecnt++;
  end

  always @(negedge clk_20m) begin
    if (lcd_e && !e_prev) begin
      p_db.push_back(lcd_db);
      p_rs.push_back(lcd_rs);
      p_t.push_back(ecnt);
      e_w = 0;
    end
    if (lcd_e) e_w++;
    if (!lcd_e && e_prev) p_w.push_back(e_w);
    e_prev = lcd_e;
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_20m);
  endtask

  task automatic clear_pulses();
    p_db.delete(); p_rs.delete(); p_t.delete(); p_w.delete();
  endtask

  task automatic wait_ready(input int lim);
    int i;
    i = 0;
    while (ready !== 1'b1 && i < lim) begin
      cyc(1);
      i++;
    end
    check("ready_timeout", ready, 1'b1);
  endtask

  task automatic check_init(input string tag);
    check({tag, "_count"}, (p_db.size() >= 6), 1'b1);
    if (p_db.size() >= 6 && p_w.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check({tag, "_byte"}, p_db[i], init_exp[i]);
        check({tag, "_rs"}, p_rs[i], 1'b0);
        check({tag, "_width"}, p_w[i], T_EH);
      end
      check({tag, "_first_e"}, p_t[0], 23);
      check({tag, "_clr_gap"}, (p_t[5] - p_t[4]) >= T_CLR, 1'b1);
    end
  endtask

  initial begin
    int d, i;
    cyc(2);
    check("rst_e", lcd_e, 1'b0);
    check("rst_db", lcd_db, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // Power-up init.
    rst = 1'b1;
    wait_ready(300);
    cyc(5);
    check_init("init");
    check("init_pulses", p_db.size(), 6);

    // Character write held for 10 clocks.
    clear_pulses();
    dbi = 8'h45; wr = 1'b1; d = ecnt;
    cyc(10); wr = 1'b0;
    cyc(30);
    check("chr_count", p_db.size(), 1);
    if (p_db.size() == 1 && p_w.size() == 1) begin
      check("chr_rs", p_rs[0], 1'b1);
      check("chr_db", p_db[0], 8'h45);
      check("chr_width", p_w[0], 3);
      check("chr_latency", p_t[0] - d, T_SU + 2);
    end

    // Clear instruction followed by a queued character.
    clear_pulses();
    direc = 8'h01; dr = 1'b1; cyc(1); dr = 1'b0; cyc(1);
    dbi = 8'h41; wr = 1'b1; cyc(1); wr = 1'b0;
    cyc(70);
    check("clr_count", p_db.size(), 2);
    if (p_db.size() == 2) begin
      check("clr_rs", p_rs[0], 1'b0);
      check("clr_db", p_db[0], 8'h01);
      check("clr_next_db", p_db[1], 8'h41);
      check("clr_gap", (p_t[1] - p_t[0]) >= T_EH + T_HD + T_CLR, 1'b1);
    end

    // Three character edges inside one transfer.
    check("ovf_before", ovf, 1'b0);
    clear_pulses();
    for (int k = 0; k < 3; k++) begin
      dbi = 8'(8'h61 + k); wr = 1'b1; cyc(1); wr = 1'b0; cyc(1);
    end
    cyc(50);
    check("ovf_count", p_db.size(), 2);
    if (p_db.size() == 2) begin
      check("ovf_db0", p_db[0], 8'h61);
      check("ovf_db1", p_db[1], 8'h62);
    end
    check("ovf_set", ovf, 1'b1);

    // Reset while E is high, then an edge during power-up wait.
    clear_pulses();
    dbi = 8'h33; wr = 1'b1; cyc(1); wr = 1'b0;
    i = 0;
    while (lcd_e !== 1'b1 && i < 20) begin
      cyc(1);
      i++;
    end
    check("eh_seen", lcd_e, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async_e", lcd_e, 1'b0);
    check("async_db", lcd_db, 8'h00);
    check("async_rs", lcd_rs, 1'b0);
    check("async_ovf", ovf, 1'b0);
    check("async_ready", ready, 1'b0);
    cyc(3);
    clear_pulses();
    rst = 1'b1;
    cyc(5);
    dbi = 8'h5A; wr = 1'b1; cyc(1); wr = 1'b0;
    cyc(3);
    check("pwr_ready", ready, 1'b0);
    wait_ready(300);
    cyc(30);
    check_init("reinit");
    check("reinit_pulses", p_db.size(), 7);
    if (p_db.size() == 7) begin
      check("pwr_edge_db", p_db[6], 8'h5A);
      check("pwr_edge_rs", p_rs[6], 1'b1);
    end

    // Simultaneous wr and dr edges.
    check("ovf_cleared", ovf, 1'b0);
    clear_pulses();
    dbi = 8'h77; direc = 8'h86; wr = 1'b1; dr = 1'b1;
    cyc(3); wr = 1'b0; dr = 1'b0;
    cyc(40);
    check("sim_count", p_db.size(), 1);
    if (p_db.size() == 1) begin
      check("sim_db", p_db[0], 8'h86);
      check("sim_rs", p_rs[0], 1'b0);
    end
    check("sim_ovf", ovf, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        wr  = ~wr;
        dbi = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        dr    = ~dr;
        direc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
      end
      cyc(1);
    end
    wr = 1'b0; dr = 1'b0;
    cyc(80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
